// File: rtl/uart_rx_frame_parser.sv
// uart_rx_frame_parser: turns bytes from a UART receiver into framed 32-bit words.
// Frame: 0xA5, LEN (1..255), LEN payload bytes, CSUM (LEN + sum of payload, mod 256).
// Payload is packed little-endian into words that are queued in a small FIFO.
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   rx_data/rx_done_sig byte from the UART receiver and its completion flag (any pulse width)
//   out_data/out_last   FIFO head word and its end-of-frame marker
//   out_valid/out_ready FIFO non-empty / consumer accept
//   frame_ok/frame_err  one-cycle frame verdict pulses; err_code holds the last error cause
//   busy                parser is inside a frame
module uart_rx_frame_parser #(
  parameter int unsigned TIMEOUT_CYC = 100000,
  parameter int unsigned FIFO_DEPTH  = 4   // power of two, >= 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_done_sig,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic        busy
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam logic [1:0] ERR_ZERO_LEN = 2'd0;
  localparam logic [1:0] ERR_CSUM     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] ERR_OVERFLOW = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LEN,
    S_PAYLOAD,
    S_CSUM
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic          r_done_q;
  logic          w_byte_stb;
  logic [7:0]    r_rem;
  logic [7:0]    r_acc;
  logic [31:0]   r_word;
  logic [1:0]    r_bidx;
  logic [TW-1:0] r_tmo;

  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic [31:0]   r_mem_data [FIFO_DEPTH];
  logic          r_mem_last [FIFO_DEPTH];

  logic          r_frame_ok;
  logic          r_frame_err;
  logic [1:0]    r_err_code;
  logic          r_busy;

  logic          w_ok_nxt;
  logic          w_err_nxt;
  logic [1:0]    w_code_nxt;

  logic          w_timeout;
  logic          w_final_byte;
  logic [31:0]   w_word_merged;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push_req;
  logic          w_push_drop;
  logic          w_push;

  // Rising-edge detect so a long rx_done_sig pulse yields one byte.
  assign w_byte_stb = rx_done_sig & ~r_done_q;

  assign w_timeout     = (r_state != S_IDLE) && !w_byte_stb && (r_tmo == TW'(TIMEOUT_CYC - 1));
  assign w_final_byte  = (r_rem == 8'd1);
  assign w_word_merged = r_word | (32'(rx_data) << {r_bidx, 3'b000});

  // Extra pointer bit separates full (MSBs differ) from empty (all equal).
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = !w_empty && out_ready;

  // A word completes on its 4th byte or on the last payload byte; a full FIFO
  // still accepts it when the head leaves on the same edge.
  assign w_push_req  = (r_state == S_PAYLOAD) && w_byte_stb && ((r_bidx == 2'd3) || w_final_byte);
  assign w_push_drop = w_push_req && w_full && !w_pop;
  assign w_push      = w_push_req && !w_push_drop;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_byte_stb && rx_data == SYNC_BYTE) w_state_nxt = S_LEN;
      S_LEN:     if (w_byte_stb) w_state_nxt = (rx_data == 8'd0) ? S_IDLE : S_PAYLOAD;
      S_PAYLOAD: begin
        if (w_byte_stb) begin
          if (w_push_drop)       w_state_nxt = S_IDLE;
          else if (w_final_byte) w_state_nxt = S_CSUM;
        end
      end
      S_CSUM:    if (w_byte_stb) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
    if (w_timeout) w_state_nxt = S_IDLE;
  end

  // Verdict outputs; timeout never coincides with a byte so the sources are exclusive.
  always_comb begin
    w_ok_nxt   = 1'b0;
    w_err_nxt  = 1'b0;
    w_code_nxt = r_err_code;
    case (r_state)
      S_LEN: begin
        if (w_byte_stb && rx_data == 8'd0) begin
          w_err_nxt  = 1'b1;
          w_code_nxt = ERR_ZERO_LEN;
        end
      end
      S_PAYLOAD: begin
        if (w_push_drop) begin
          w_err_nxt  = 1'b1;
          w_code_nxt = ERR_OVERFLOW;
        end
      end
      S_CSUM: begin
        if (w_byte_stb) begin
          if (rx_data == r_acc) begin
            w_ok_nxt = 1'b1;
          end else begin
            w_err_nxt  = 1'b1;
            w_code_nxt = ERR_CSUM;
          end
        end
      end
      default: ;
    endcase
    if (w_timeout) begin
      w_err_nxt  = 1'b1;
      w_code_nxt = ERR_TIMEOUT;
    end
  end

  // Output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
      r_err_code  <= 2'd0;
      r_busy      <= 1'b0;
    end else begin
      r_frame_ok  <= w_ok_nxt;
      r_frame_err <= w_err_nxt;
      r_err_code  <= w_code_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  // Byte edge detect and inter-byte timeout counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_done_q <= 1'b0;
      r_tmo    <= '0;
    end else begin
      r_done_q <= rx_done_sig;
      if (r_state == S_IDLE || w_byte_stb) r_tmo <= '0;
      else                                 r_tmo <= r_tmo + TW'(1);
    end
  end

  // Length, checksum and word assembly.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rem  <= 8'd0;
      r_acc  <= 8'd0;
      r_word <= 32'd0;
      r_bidx <= 2'd0;
    end else if (w_byte_stb) begin
      case (r_state)
        S_LEN: begin
          if (rx_data != 8'd0) begin
            r_rem  <= rx_data;
            r_acc  <= rx_data;
            r_word <= 32'd0;
            r_bidx <= 2'd0;
          end
        end
        S_PAYLOAD: begin
          r_acc <= r_acc + rx_data;
          r_rem <= r_rem - 8'd1;
          if (w_push_req) begin
            r_word <= 32'd0;
            r_bidx <= 2'd0;
          end else begin
            r_word <= w_word_merged;
            r_bidx <= r_bidx + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output word FIFO; words already queued survive frame errors.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        r_mem_data[i] <= 32'd0;
        r_mem_last[i] <= 1'b0;
      end
    end else begin
      if (w_push) begin
        r_mem_data[r_wr_ptr[AW-1:0]] <= w_word_merged;
        r_mem_last[r_wr_ptr[AW-1:0]] <= w_final_byte;
        r_wr_ptr                     <= r_wr_ptr + (AW+1)'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  assign out_data  = r_mem_data[r_rd_ptr[AW-1:0]];
  assign out_last  = r_mem_last[r_rd_ptr[AW-1:0]];
  assign out_valid = !w_empty;
  assign frame_ok  = r_frame_ok;
  assign frame_err = r_frame_err;
  assign err_code  = r_err_code;
  assign busy      = r_busy;

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Bench for uart_rx_frame_parser: a frame-level reference model (byte queues,
// plain sums) predicts every output each cycle; directed frames pin the model
// with hand-computed words and verdicts; random frames exercise the rest.
module tb_uart_rx_frame_parser;

  localparam int unsigned TMO   = 40;
  localparam int unsigned DEPTH = 4;

  logic        clock       = 1'b0;
  logic        reset       = 1'b1;
  logic [7:0]  rx_data     = 8'd0;
  logic        rx_done_sig = 1'b0;
  logic        ready_force = 1'b1;
  logic        rand_mode   = 1'b0;
  logic        rnd_ready   = 1'b1;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_valid;
  logic        frame_ok;
  logic        frame_err;
  logic [1:0]  err_code;
  logic        busy;

  assign out_ready = rand_mode ? rnd_ready : ready_force;

  uart_rx_frame_parser #(.TIMEOUT_CYC(TMO), .FIFO_DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_done_sig(rx_done_sig),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .frame_ok   (frame_ok),
    .frame_err  (frame_err),
    .err_code   (err_code),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    #1;
    rnd_ready = ($urandom_range(0, 3) != 0);
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  cur[$];     // bytes of the frame in progress, sync byte first
  logic [32:0] mfifo[$];   // {last, word}
  int          idle_cnt;
  logic        m_prev;
  logic        m_ok, m_err;
  logic [1:0]  m_code;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      cur.delete();
      mfifo.delete();
      idle_cnt = 0;
      m_prev   = 1'b0;
      m_ok     = 1'b0;
      m_err    = 1'b0;
      m_code   = 2'd0;
    end else begin
      bit          stb, pop, do_push;
      logic [32:0] pw;
      logic [7:0]  b;
      stb     = rx_done_sig && !m_prev;
      m_prev  = rx_done_sig;
      b       = rx_data;
      pop     = (mfifo.size() > 0) && out_ready;
      m_ok    = 1'b0;
      m_err   = 1'b0;
      do_push = 1'b0;
      pw      = '0;
      if (stb) begin
        idle_cnt = 0;
        if (cur.size() == 0) begin
          if (b == 8'hA5) cur.push_back(b);
        end else if (cur.size() == 1) begin
          if (b == 8'd0) begin
            m_err = 1'b1; m_code = 2'd0; cur.delete();
          end else cur.push_back(b);
        end else begin
          int len, n, s;
          len = int'(cur[1]);
          n   = cur.size() - 2;
          if (n < len) begin
            cur.push_back(b);
            if ((n % 4) == 3 || n == len - 1) begin
              pw[32] = (n == len - 1);
              for (int k = 0; k <= n % 4; k++) pw[8*k +: 8] = cur[2 + n - (n % 4) + k];
              if (mfifo.size() == DEPTH && !pop) begin
                m_err = 1'b1; m_code = 2'd3; cur.delete();
              end else do_push = 1'b1;
            end
          end else begin
            s = 0;
            for (int k = 1; k < cur.size(); k++) s += int'(cur[k]);
            if (b == 8'(s)) m_ok = 1'b1;
            else begin m_err = 1'b1; m_code = 2'd1; end
            cur.delete();
          end
        end
      end else if (cur.size() > 0) begin
        idle_cnt++;
        if (idle_cnt == TMO) begin
          m_err = 1'b1; m_code = 2'd2; cur.delete(); idle_cnt = 0;
        end
      end
      if (pop) void'(mfifo.pop_front());
      if (do_push) mfifo.push_back(pw);
    end
  end

  // ---------------- compare process + observation logs ----------------
  logic [32:0] got[$];   // words seen leaving the DUT
  int          evt[$];   // 4 = frame_ok, 0..3 = frame_err with that code

  always @(negedge clock) begin
    if (reset) begin
      check("reset_outputs", {out_valid, out_data, out_last, frame_ok, frame_err, err_code, busy}, 64'd0);
    end else begin
      check("out_valid", out_valid, mfifo.size() > 0);
      if (mfifo.size() > 0) check("head_word", {out_last, out_data}, mfifo[0]);
      check("frame_ok", frame_ok, m_ok);
      check("frame_err", frame_err, m_err);
      check("err_code", err_code, m_code);
      check("busy", busy, cur.size() > 0);
      if (out_valid && out_ready) got.push_back({out_last, out_data});
      if (frame_ok) evt.push_back(4);
      if (frame_err) evt.push_back(int'(err_code));
    end
  end

  function automatic logic [63:0] gw(input int i);
    return (i < got.size()) ? 64'(got[i]) : '1;
  endfunction

  function automatic logic [63:0] ge(input int i);
    return (i < evt.size()) ? 64'(evt[i]) : '1;
  endfunction

  // ---------------- stimulus ----------------
  logic [7:0] seq[$];

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    rx_data     = b;
    rx_done_sig = 1'b1;
    idle(hold);
    rx_done_sig = 1'b0;
    idle(gap);
  endtask

  // hold == 0 picks a random pulse width per byte.
  task automatic send_seq(input int hold);
    foreach (seq[i]) send_byte(seq[i], (hold == 0) ? $urandom_range(1, 3) : hold, $urandom_range(1, 3));
  endtask

  task automatic clear_logs();
    got.delete();
    evt.delete();
  endtask

  initial begin
    idle(3);
    check("reset_busy_literal", busy, 1'b0);
    reset = 1'b0;
    idle(2);

    // Two words; checksum = 0x05 + 0x11 + 0x22 + 0x33 + 0x44 + 0x55 = 0x104 -> 0x04.
    clear_logs();
    seq = '{8'hA5, 8'h05, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h04};
    send_seq(1);
    idle(6);
    check("t1_nwords", got.size(), 2);
    check("t1_w0", gw(0), {31'd0, 1'b0, 32'h44332211});
    check("t1_w1", gw(1), {31'd0, 1'b1, 32'h00000055});
    check("t1_evt", ge(0), 4);

    // Same frame with checksum 0xFA is a checksum error.
    clear_logs();
    seq = '{8'hA5, 8'h05, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'hFA};
    send_seq(1);
    idle(6);
    check("t1b_evt", ge(0), 1);

    // Bad checksum after a partial word.
    clear_logs();
    seq = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h00};
    send_seq(1);
    idle(6);
    check("t2_nwords", got.size(), 1);
    check("t2_w0", gw(0), {31'd0, 1'b1, 32'h00000201});
    check("t2_evt", ge(0), 1);

    // Zero length.
    clear_logs();
    seq = '{8'hA5, 8'h00};
    send_seq(1);
    idle(4);
    check("t3_nwords", got.size(), 0);
    check("t3_evt", ge(0), 0);
    check("t3_busy", busy, 1'b0);

    // Timeout mid-frame.
    clear_logs();
    seq = '{8'hA5, 8'h03, 8'h07};
    send_seq(1);
    idle(TMO + 5);
    check("t4_nwords", got.size(), 0);
    check("t4_nevt", evt.size(), 1);
    check("t4_evt", ge(0), 2);

    // FIFO overflow: 20-byte payload with consumer stalled; 5th word dropped.
    clear_logs();
    ready_force = 1'b0;
    seq = '{8'hA5, 8'd20};
    for (int i = 1; i <= 20; i++) seq.push_back(8'(i));
    seq.push_back(8'hE6);
    send_seq(1);
    idle(4);
    check("t5_evt", ge(0), 3);
    check("t5_full", out_valid, 1'b1);
    ready_force = 1'b1;
    idle(10);
    check("t5_nwords", got.size(), 4);
    check("t5_w0", gw(0), {31'd0, 1'b0, 32'h04030201});
    check("t5_w3", gw(3), {31'd0, 1'b0, 32'h100F0E0D});

    // Same frame, but the head leaves on the edge of the 5th push.
    clear_logs();
    ready_force = 1'b0;
    seq = '{8'hA5, 8'd20};
    for (int i = 1; i <= 19; i++) seq.push_back(8'(i));
    send_seq(1);
    rx_data     = 8'd20;
    rx_done_sig = 1'b1;
    ready_force = 1'b1;
    idle(1);
    ready_force = 1'b0;
    rx_done_sig = 1'b0;
    idle(2);
    send_byte(8'hE6, 1, 2);  // 20 + (1+..+20) = 230
    ready_force = 1'b1;
    idle(10);
    check("t6_evt", ge(0), 4);
    check("t6_nwords", got.size(), 5);
    check("t6_w0", gw(0), {31'd0, 1'b0, 32'h04030201});
    check("t6_w4", gw(4), {31'd0, 1'b1, 32'h14131211});

    // Long rx_done_sig pulses and a stray 0x5A in idle.
    clear_logs();
    seq = '{8'h5A, 8'hA5, 8'h01, 8'h33, 8'h34};
    send_seq(3);
    idle(6);
    check("t7_nwords", got.size(), 1);
    check("t7_w0", gw(0), {31'd0, 1'b1, 32'h00000033});
    check("t7_nevt", evt.size(), 1);
    check("t7_evt", ge(0), 4);

    // Reset mid-frame drops the queued word and the partial frame silently.
    clear_logs();
    ready_force = 1'b0;
    seq = '{8'hA5, 8'h05, 8'h11, 8'h22, 8'h33, 8'h44};
    send_seq(1);
    check("t8_pre_valid", out_valid, 1'b1);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    ready_force = 1'b1;
    idle(TMO + 5);
    check("t8_valid", out_valid, 1'b0);
    check("t8_busy", busy, 1'b0);
    check("t8_nevt", evt.size(), 0);

    // Random frames under random back-pressure.
    rand_mode = 1'b1;
    for (int f = 0; f < 80; f++) begin
      int kind, len, cnt;
      logic [7:0] s, b;
      kind = $urandom_range(0, 9);
      seq.delete();
      if (kind <= 5 || kind == 9) begin
        len = $urandom_range(1, 12);
        seq.push_back(8'hA5);
        seq.push_back(8'(len));
        s = 8'(len);
        for (int i = 0; i < len; i++) begin
          b = 8'($urandom);
          seq.push_back(b);
          s = s + b;
        end
        seq.push_back((kind == 5) ? s + 8'd1 : s);
        send_seq(0);
      end else if (kind == 6) begin
        seq = '{8'hA5, 8'h00};
        send_seq(0);
      end else if (kind == 7) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h5A;
        seq.push_back(b);
        send_seq(0);
      end else begin
        len = $urandom_range(2, 10);
        cnt = $urandom_range(0, len - 1);
        seq.push_back(8'hA5);
        seq.push_back(8'(len));
        for (int i = 0; i < cnt; i++) seq.push_back(8'($urandom));
        send_seq(0);
        idle(TMO + 3);
      end
      idle($urandom_range(1, 4));
    end
    rand_mode   = 1'b0;
    ready_force = 1'b1;
    idle(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
